// File: rtl/sap_1_controller_sequencer_pkg.sv
// SAP-1 controller-sequencer shared constants: opcodes, control-word
// bit positions, one-hot T-states and the bus types built on them.
package sap_1_pkg;

    localparam int OPCODE_W = 4;
    localparam int CON_W    = 12;
    localparam int T_STATES = 6;

    typedef logic [OPCODE_W-1:0] opcode_t;
    typedef logic [CON_W-1:0]    con_t;
    typedef logic [T_STATES-1:0] tstate_t;

    localparam opcode_t OP_LDA = 4'h0;
    localparam opcode_t OP_ADD = 4'h1;
    localparam opcode_t OP_SUB = 4'h2;
    localparam opcode_t OP_OUT = 4'hE;
    localparam opcode_t OP_HLT = 4'hF;

    localparam int CON_CP = 11;
    localparam int CON_EP = 10;
    localparam int CON_LM = 9;
    localparam int CON_CE = 8;
    localparam int CON_LI = 7;
    localparam int CON_EI = 6;
    localparam int CON_LA = 5;
    localparam int CON_EA = 4;
    localparam int CON_SU = 3;
    localparam int CON_EU = 2;
    localparam int CON_LB = 1;
    localparam int CON_LO = 0;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    function automatic con_t con_bit(input int idx);
        con_bit = con_t'(1) << idx;
    endfunction

endpackage

// File: rtl/sap_1_controller_sequencer_if.sv
// Bus between the SAP-1 sequencer (master) and the datapath/IR side (slave):
// opcode in, control word and sequencing status out.
interface sap_1_controller_sequencer_if;
    import sap_1_pkg::*;

    opcode_t opcode;
    con_t    con;
    tstate_t t_state;
    logic    halted;
    logic    instr_done;

    modport master (
        input  opcode,
        output con,
        output t_state,
        output halted,
        output instr_done
    );

    modport slave (
        output opcode,
        input  con,
        input  t_state,
        input  halted,
        input  instr_done
    );

endinterface

// File: rtl/sap_1_ring_counter.sv
// Six-state one-hot ring counter T1..T6 with hold; any non-one-hot
// state falls back to T1 on the next edge.
module sap_1_ring_counter
    import sap_1_pkg::*;
(
    input  logic    Clk,
    input  logic    Clr,
    input  logic    hold,
    output tstate_t t_state
);

    tstate_t t_q;
    tstate_t t_d;
    logic    onehot;

    assign onehot = (t_q != '0) && ((t_q & (t_q - tstate_t'(1))) == '0);

    always_comb begin
        t_d = t_q;
        if (!onehot) begin
            t_d = T1;
        end else if (!hold) begin
            t_d = {t_q[T_STATES-2:0], t_q[T_STATES-1]};
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            t_q <= T1;
        end else begin
            t_q <= t_d;
        end
    end

    assign t_state = t_q;

endmodule

// File: rtl/sap_1_controller_sequencer.sv
// SAP-1 controller-sequencer: ring counter plus per-T-state microcode decode.
// Optional halt support is enabled with the SAP1_CTRL_HALT_EN macro.
module sap_1_controller_sequencer #(
    parameter int OPCODE_W = sap_1_pkg::OPCODE_W,
    parameter int T_STATES = sap_1_pkg::T_STATES,
    parameter int CON_W    = sap_1_pkg::CON_W
) (
    input  logic                          Clk,
    input  logic                          Clr,
    sap_1_controller_sequencer_if.master  bus
);
    import sap_1_pkg::*;

    if (OPCODE_W != 4) begin : g_bad_opcode_w
        $error("OPCODE_W must be 4");
    end
    if (T_STATES != 6) begin : g_bad_t_states
        $error("T_STATES must be 6");
    end
    if (CON_W != 12) begin : g_bad_con_w
        $error("CON_W must be 12");
    end

    tstate_t t_state;
    logic    hold;
    logic    halted_w;
    con_t    con_c;
    opcode_t op;

    assign op = bus.opcode;

`ifdef SAP1_CTRL_HALT_EN
    logic halted_q;
    logic halted_d;
    logic hlt_now;

    // Hold the ring on the same edge that latches halted so it freezes at T4.
    assign hlt_now  = t_state[3] & (op == OP_HLT) & ~halted_q;
    assign halted_d = halted_q | hlt_now;
    assign hold     = halted_q | hlt_now;

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halted_w = halted_q;
`else
    assign hold     = 1'b0;
    assign halted_w = 1'b0;
`endif

    sap_1_ring_counter u_ring (
        .Clk     (Clk),
        .Clr     (Clr),
        .hold    (hold),
        .t_state (t_state)
    );

    always_comb begin
        con_c = '0;
        unique case (1'b1)
            t_state[0]: con_c = con_bit(CON_EP) | con_bit(CON_LM);
            t_state[1]: con_c = con_bit(CON_CP);
            t_state[2]: con_c = con_bit(CON_CE) | con_bit(CON_LI);
            t_state[3]: begin
                if (op == OP_LDA || op == OP_ADD || op == OP_SUB) begin
                    con_c = con_bit(CON_EI) | con_bit(CON_LM);
                end else if (op == OP_OUT) begin
                    con_c = con_bit(CON_EA) | con_bit(CON_LO);
                end
            end
            t_state[4]: begin
                if (op == OP_LDA) begin
                    con_c = con_bit(CON_CE) | con_bit(CON_LA);
                end else if (op == OP_ADD || op == OP_SUB) begin
                    con_c = con_bit(CON_CE) | con_bit(CON_LB);
                end
            end
            t_state[5]: begin
                if (op == OP_ADD) begin
                    con_c = con_bit(CON_EU) | con_bit(CON_LA);
                end else if (op == OP_SUB) begin
                    con_c = con_bit(CON_SU) | con_bit(CON_EU)
                          | con_bit(CON_LA);
                end
            end
            default: con_c = '0;
        endcase
        if (Clr || halted_w) begin
            con_c = '0;
        end
    end

    assign bus.con        = con_c;
    assign bus.t_state    = t_state;
    assign bus.halted     = halted_w;
    assign bus.instr_done = t_state[5] & ~halted_w & ~Clr;

endmodule

// File: tb/tb_sap_1_controller_sequencer.sv
// Directed bench for the SAP-1 controller-sequencer: fetch/execute
// control words, instr_done timing, halt behaviour and async Clr.
module tb_sap_1_controller_sequencer;

    logic Clk;
    logic Clr;
    int   n_chk;
    int   n_pass;

    sap_1_controller_sequencer_if bus ();

    sap_1_controller_sequencer dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus)
    );

    initial begin
        Clk = 1'b1;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Starts at T1 (already settled), checks all six states, ends at next T1.
    task automatic instr(input logic [3:0] op, input logic [11:0] c4,
                         input logic [11:0] c5, input logic [11:0] c6);
        logic [11:0] ex [6];
        ex[0] = 12'h600;
        ex[1] = 12'h800;
        ex[2] = 12'h180;
        ex[3] = c4;
        ex[4] = c5;
        ex[5] = c6;
        bus.opcode = op;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            chk($sformatf("op%0h_con_T%0d", op, i + 1), 32'(bus.con),
                32'(ex[i]));
            chk($sformatf("op%0h_t_T%0d", op, i + 1), 32'(bus.t_state),
                32'(6'b1 << i));
            chk($sformatf("op%0h_done_T%0d", op, i + 1),
                32'(bus.instr_done), 32'(i == 5));
        end
        tick();
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        Clr        = 1'b1;
        bus.opcode = 4'h0;

        #3;
        chk("rst_t", 32'(bus.t_state), 32'h01);
        chk("rst_con", 32'(bus.con), 32'h000);
        chk("rst_done", 32'(bus.instr_done), 32'h0);
        chk("rst_halt", 32'(bus.halted), 32'h0);
        #9;
        chk("rst_edge_t", 32'(bus.t_state), 32'h01);
        chk("rst_edge_con", 32'(bus.con), 32'h000);
        #3;
        Clr = 1'b0;
        #1;

        instr(4'h0, 12'h240, 12'h120, 12'h000);
        instr(4'h0, 12'h240, 12'h120, 12'h000);
        instr(4'h1, 12'h240, 12'h102, 12'h024);
        instr(4'h2, 12'h240, 12'h102, 12'h02C);
        instr(4'hE, 12'h011, 12'h000, 12'h000);
        instr(4'h7, 12'h000, 12'h000, 12'h000);

        // opcode garbage during fetch must not disturb T1-T3
        bus.opcode = 4'hE;
        chk("fetch_ign_T1", 32'(bus.con), 32'h600);
        instr(4'h1, 12'h240, 12'h102, 12'h024);

`ifdef SAP1_CTRL_HALT_EN
        bus.opcode = 4'hF;
        tick();
        tick();
        tick();
        chk("hlt_T4_t", 32'(bus.t_state), 32'h08);
        chk("hlt_T4_con", 32'(bus.con), 32'h000);
        chk("hlt_T4_halt", 32'(bus.halted), 32'h0);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("hlt_t_%0d", k), 32'(bus.t_state), 32'h08);
            chk($sformatf("hlt_h_%0d", k), 32'(bus.halted), 32'h1);
            chk($sformatf("hlt_c_%0d", k), 32'(bus.con), 32'h000);
            chk($sformatf("hlt_d_%0d", k), 32'(bus.instr_done), 32'h0);
        end
        #2;
        Clr = 1'b1;
        #1;
        chk("hlt_clr_t", 32'(bus.t_state), 32'h01);
        chk("hlt_clr_h", 32'(bus.halted), 32'h0);
        chk("hlt_clr_con", 32'(bus.con), 32'h000);
        #1;
        Clr = 1'b0;
        #1;
        chk("hlt_rel_con", 32'(bus.con), 32'h600);
        chk("hlt_rel_h", 32'(bus.halted), 32'h0);
        tick();
        chk("hlt_rel_T2", 32'(bus.t_state), 32'h02);
        tick();
        tick();
        tick();
        tick();
        tick();
`else
        instr(4'hF, 12'h000, 12'h000, 12'h000);
        chk("nohlt_halt", 32'(bus.halted), 32'h0);
`endif

        // async Clr in the middle of T5
        bus.opcode = 4'h1;
        chk("mid_T1", 32'(bus.t_state), 32'h01);
        tick();
        tick();
        tick();
        tick();
        chk("mid_T5_con", 32'(bus.con), 32'h102);
        #2;
        Clr = 1'b1;
        #1;
        chk("mid_clr_t", 32'(bus.t_state), 32'h01);
        chk("mid_clr_con", 32'(bus.con), 32'h000);
        chk("mid_clr_done", 32'(bus.instr_done), 32'h0);
        #2;
        Clr = 1'b0;
        #1;
        instr(4'h2, 12'h240, 12'h102, 12'h02C);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
